// File: rtl/control_sequencer.sv
// Multi-cycle sequencer beside the control decoder: pipeline advance, memory write strobe,
// I/O handshakes, PAUSE/resume and sticky HALT. Optional I/O timeout: CTRL_IO_TIMEOUT_EN.
module control_sequencer #(
  parameter int unsigned ID_WIDTH          = 7,
  parameter int unsigned MEM_WAIT          = 0,
  parameter int unsigned IO_TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_WIDTH-1:0] id,
  input  logic                id_valid,
  input  logic                confirmation,
  input  logic                resume,
  output logic                enable,
  output logic                allow_write_on_memory,
  output logic                is_input,
  output logic                is_output,
  output logic                halted,
  output logic                fault
);

  localparam int unsigned WAIT_W = 4;
`ifdef CTRL_IO_TIMEOUT_EN
  localparam int unsigned TMO_W  = $clog2(IO_TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_MEM_WAIT = 3'd1,
    S_IO_REQ   = 3'd2,
    S_IO_REL   = 3'd3,
    S_PAUSE    = 3'd4,
    S_HALT     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  // Elaboration-time parameter sanity check
  if (MEM_WAIT > 15 || IO_TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("control_sequencer: MEM_WAIT must be 0..15 and IO_TIMEOUT_CYCLES nonzero");
  end

  function automatic logic id_is(input logic [ID_WIDTH-1:0] v, input int unsigned n);
    return v == ID_WIDTH'(n);
  endfunction

  // Instruction class decode
  logic cls_mem, cls_store, cls_out, cls_in, cls_pause, cls_halt;

  always_comb begin
    cls_mem   = (id >= ID_WIDTH'(39) && id <= ID_WIDTH'(55)) || id_is(id, 67) || id_is(id, 68);
    cls_store = id_is(id, 40) || id_is(id, 41) || id_is(id, 42) || id_is(id, 48) ||
                id_is(id, 50) || id_is(id, 52) || id_is(id, 54) || id_is(id, 67);
    cls_out   = id_is(id, 69);
    cls_pause = id_is(id, 70);
    cls_in    = id_is(id, 71);
    cls_halt  = id_is(id, 75);
  end

  state_t              state, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic                io_is_out, io_is_out_d;
  logic                store_q, store_d;
  logic                resume_q;
  logic                enable_c, write_c;
  logic                is_input_d, is_output_d, halted_d;
`ifdef CTRL_IO_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_cnt, tmo_d;
  logic                fault_d;
`endif

  // Next-state, commit strobes and next registered outputs
  always_comb begin
    state_d     = state;
    wait_d      = wait_cnt;
    io_is_out_d = io_is_out;
    store_d     = store_q;
    enable_c    = 1'b0;
    write_c     = 1'b0;
`ifdef CTRL_IO_TIMEOUT_EN
    tmo_d       = tmo_cnt;
`endif

    unique case (state)
      S_RUN: begin
        if (id_valid) begin
          if (cls_halt) begin
            state_d = S_HALT;
          end else if (cls_out || cls_in) begin
            state_d     = S_IO_REQ;
            io_is_out_d = cls_out;
`ifdef CTRL_IO_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end else if (cls_pause) begin
            state_d = S_PAUSE;
          end else if (cls_mem && MEM_WAIT != 0) begin
            state_d = S_MEM_WAIT;
            wait_d  = WAIT_W'(MEM_WAIT);
            store_d = cls_store;
          end else begin
            enable_c = 1'b1;
            write_c  = cls_store;
          end
        end
      end

      S_MEM_WAIT: begin
        if (wait_cnt == WAIT_W'(1)) begin
          enable_c = 1'b1;
          write_c  = store_q;
          state_d  = S_RUN;
        end else begin
          wait_d = wait_cnt - WAIT_W'(1);
        end
      end

      S_IO_REQ: begin
        if (confirmation) begin
          enable_c = 1'b1;
          state_d  = S_IO_REL;
`ifdef CTRL_IO_TIMEOUT_EN
        end else if (tmo_cnt == TMO_W'(IO_TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
`endif
        end
      end

      S_IO_REL: begin
        if (!confirmation) state_d = S_RUN;
      end

      // Only a fresh rising edge of resume releases PAUSE
      S_PAUSE: begin
        if (resume && !resume_q) begin
          enable_c = 1'b1;
          state_d  = S_RUN;
        end
      end

      S_HALT, S_FAULT: state_d = state;

      default: state_d = S_RUN;
    endcase

    is_output_d = (state_d == S_IO_REQ && io_is_out_d) || state_d == S_PAUSE;
    is_input_d  = (state_d == S_IO_REQ && !io_is_out_d) || state_d == S_PAUSE;
    halted_d    = state_d == S_HALT;
`ifdef CTRL_IO_TIMEOUT_EN
    fault_d     = state_d == S_FAULT;
`endif
  end

  // Strobes are forced low while reset is held so an interrupted access never commits
  assign enable                = enable_c & reset;
  assign allow_write_on_memory = write_c & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      io_is_out <= 1'b0;
      store_q   <= 1'b0;
      resume_q  <= 1'b0;
      is_input  <= 1'b0;
      is_output <= 1'b0;
      halted    <= 1'b0;
`ifdef CTRL_IO_TIMEOUT_EN
      tmo_cnt   <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_d;
      io_is_out <= io_is_out_d;
      store_q   <= store_d;
      resume_q  <= resume;
      is_input  <= is_input_d;
      is_output <= is_output_d;
      halted    <= halted_d;
`ifdef CTRL_IO_TIMEOUT_EN
      tmo_cnt   <= tmo_d;
      fault     <= fault_d;
`endif
    end
  end

`ifndef CTRL_IO_TIMEOUT_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed table and corner sequences on MEM_WAIT=3 and MEM_WAIT=0
// instances, then randomized traffic checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_control_sequencer;
  localparam int unsigned IDW     = 7;
  localparam int          TMO_CYC = 8;
`ifdef CTRL_IO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [IDW-1:0] id;
  logic           id_valid, confirmation, resume;
  logic           en3, wr3, in3, out3, hl3, ft3;
  logic           en0, wr0, in0, out0, hl0, ft0;
  logic [5:0]     o3, o0;

  assign o3 = {en3, wr3, in3, out3, hl3, ft3};
  assign o0 = {en0, wr0, in0, out0, hl0, ft0};

  always #5 clock = ~clock;

  control_sequencer #(.ID_WIDTH(IDW), .MEM_WAIT(3), .IO_TIMEOUT_CYCLES(TMO_CYC)) dut3 (
    .clock(clock), .reset(reset), .id(id), .id_valid(id_valid),
    .confirmation(confirmation), .resume(resume),
    .enable(en3), .allow_write_on_memory(wr3), .is_input(in3), .is_output(out3),
    .halted(hl3), .fault(ft3)
  );

  control_sequencer #(.ID_WIDTH(IDW), .MEM_WAIT(0), .IO_TIMEOUT_CYCLES(TMO_CYC)) dut0 (
    .clock(clock), .reset(reset), .id(id), .id_valid(id_valid),
    .confirmation(confirmation), .resume(resume),
    .enable(en0), .allow_write_on_memory(wr0), .is_input(in0), .is_output(out0),
    .halted(hl0), .fault(ft0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {en,wr,in,out,halt,fault}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ex(input bit en, input bit wr, input bit is_in, input bit is_out,
                                    input bit hl, input bit ft);
    return {en, wr, is_in, is_out, hl, ft};
  endfunction

  // Inputs change just after the rising edge; outputs are sampled on the falling edge
  task automatic drive(input bit r, input int i, input bit v, input bit c, input bit rs);
    @(posedge clock);
    #1;
    reset = r; id = IDW'(i); id_valid = v; confirmation = c; resume = rs;
    @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int commit_at;   // cycle of the pending memory commit, -1 if none
    bit store;
    int io;          // 0 none, 1 input, 2 output
    bit acked;
    int io_age;
    bit paused;
    bit halt;
    bit flt;
    bit res_prev;
  } mdl_t;

  function automatic bit id_mem(input int i);
    return (i >= 39 && i <= 55) || i == 67 || i == 68;
  endfunction

  function automatic bit id_store(input int i);
    case (i)
      40, 41, 42, 48, 50, 52, 54, 67: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.cyc = 0; m.commit_at = -1; m.store = 1'b0; m.io = 0; m.acked = 1'b0; m.io_age = 0;
    m.paused = 1'b0; m.halt = 1'b0; m.flt = 1'b0; m.res_prev = 1'b0;
    return m;
  endfunction

  task automatic mdl_step(inout mdl_t m, input int mw, input bit r, input int i, input bit v,
                          input bit c, input bit rs, output logic [5:0] exp);
    bit en, wr, e_in, e_out, hl, ft;
    if (!r) begin
      exp = '0;
      m   = mdl_reset();
      return;
    end
    e_out = m.paused || (m.io == 2 && !m.acked);
    e_in  = m.paused || (m.io == 1 && !m.acked);
    hl    = m.halt;
    ft    = m.flt;
    en    = 1'b0;
    wr    = 1'b0;
    if (m.halt || m.flt) begin
      en = 1'b0;
    end else if (m.commit_at >= 0) begin
      if (m.cyc == m.commit_at) begin
        en = 1'b1; wr = m.store; m.commit_at = -1;
      end
    end else if (m.io != 0 && !m.acked) begin
      if (c) begin
        en = 1'b1; m.acked = 1'b1;
      end else if (TMO_EN && m.io_age + 1 >= TMO_CYC) begin
        m.flt = 1'b1; m.io = 0;
      end else begin
        m.io_age++;
      end
    end else if (m.io != 0) begin
      if (!c) m.io = 0;
    end else if (m.paused) begin
      if (rs && !m.res_prev) begin
        en = 1'b1; m.paused = 1'b0;
      end
    end else if (v) begin
      if (i == 75) m.halt = 1'b1;
      else if (i == 69 || i == 71) begin
        m.io = (i == 69) ? 2 : 1; m.acked = 1'b0; m.io_age = 0;
      end else if (i == 70) m.paused = 1'b1;
      else if (id_mem(i) && mw > 0) begin
        m.commit_at = m.cyc + mw; m.store = id_store(i);
      end else begin
        en = 1'b1; wr = id_store(i);
      end
    end
    exp = {en, wr, e_in, e_out, hl, ft};
    m.res_prev = rs;
    m.cyc++;
  endtask

  // ---------------- table of single-cycle decode vectors ----------------
  typedef struct {
    int         id;
    bit         v;
    logic [1:0] e0;  // {enable, write} for MEM_WAIT=0
    logic [1:0] e3;  // {enable, write} for MEM_WAIT=3
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int i, input bit v, input logic [1:0] e0, input logic [1:0] e3);
    vec_t r;
    r.id = i; r.v = v; r.e0 = e0; r.e3 = e3;
    return r;
  endfunction

  mdl_t       m3, m0;
  logic [5:0] e3, e0;
  bit         rc, rrs;

  initial begin
    tbl.push_back(mk(4,   1, 2'b10, 2'b10));
    tbl.push_back(mk(4,   0, 2'b00, 2'b00));
    tbl.push_back(mk(0,   1, 2'b10, 2'b10));
    tbl.push_back(mk(38,  1, 2'b10, 2'b10));
    tbl.push_back(mk(39,  1, 2'b10, 2'b00));
    tbl.push_back(mk(40,  1, 2'b11, 2'b00));
    tbl.push_back(mk(41,  1, 2'b11, 2'b00));
    tbl.push_back(mk(42,  1, 2'b11, 2'b00));
    tbl.push_back(mk(43,  1, 2'b10, 2'b00));
    tbl.push_back(mk(44,  1, 2'b10, 2'b00));
    tbl.push_back(mk(48,  1, 2'b11, 2'b00));
    tbl.push_back(mk(49,  1, 2'b10, 2'b00));
    tbl.push_back(mk(50,  1, 2'b11, 2'b00));
    tbl.push_back(mk(51,  1, 2'b10, 2'b00));
    tbl.push_back(mk(52,  1, 2'b11, 2'b00));
    tbl.push_back(mk(54,  1, 2'b11, 2'b00));
    tbl.push_back(mk(55,  1, 2'b10, 2'b00));
    tbl.push_back(mk(56,  1, 2'b10, 2'b10));
    tbl.push_back(mk(66,  1, 2'b10, 2'b10));
    tbl.push_back(mk(67,  1, 2'b11, 2'b00));
    tbl.push_back(mk(68,  1, 2'b10, 2'b00));
    tbl.push_back(mk(72,  1, 2'b10, 2'b10));
    tbl.push_back(mk(127, 1, 2'b10, 2'b10));
    tbl.push_back(mk(40,  0, 2'b00, 2'b00));
    tbl.push_back(mk(69,  1, 2'b00, 2'b00));
    tbl.push_back(mk(70,  1, 2'b00, 2'b00));
    tbl.push_back(mk(71,  1, 2'b00, 2'b00));
    tbl.push_back(mk(75,  1, 2'b00, 2'b00));

    reset = 1'b0; id = IDW'(4); id_valid = 1'b1; confirmation = 1'b0; resume = 1'b0;

    // T1: reset state, reset during IO_REQ, single-cycle instruction after release
    drive(0, 4, 1, 0, 0);
    chk("reset_state_mw3", o3, '0);
    chk("reset_state_mw0", o0, '0);
    drive(1, 69, 1, 0, 0);
    chk("t1_out_issue_mw3", o3, '0);
    drive(1, 69, 1, 0, 0);
    chk("t1_ioreq_mw3", o3, ex(0, 0, 0, 1, 0, 0));
    chk("t1_ioreq_mw0", o0, ex(0, 0, 0, 1, 0, 0));
    drive(0, 69, 1, 0, 0);
    chk("t1_reset_mid_mw3", o3, '0);
    chk("t1_reset_mid_mw0", o0, '0);
    drive(1, 4, 1, 0, 0);
    chk("t1_after_mw3", o3, ex(1, 0, 0, 0, 0, 0));
    chk("t1_after_mw0", o0, ex(1, 0, 0, 0, 0, 0));

    // Decode table, each vector from a fresh reset
    foreach (tbl[k]) begin
      drive(0, 0, 0, 0, 0);
      drive(1, tbl[k].id, tbl[k].v, 0, 0);
      chk($sformatf("tbl_mw0[%0d] id=%0d v=%0d", k, tbl[k].id, tbl[k].v), o0, {tbl[k].e0, 4'b0});
      chk($sformatf("tbl_mw3[%0d] id=%0d v=%0d", k, tbl[k].id, tbl[k].v), o3, {tbl[k].e3, 4'b0});
    end

    // T2: memory wait states, store and non-store
    for (int s = 0; s < 2; s++) begin
      int     mid;
      mid = (s == 0) ? 40 : 44;
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        drive(1, mid, 1, 0, 0);
        chk($sformatf("t2_mw3 id=%0d cyc%0d", mid, k), o3,
            (k == 3) ? ex(1, s == 0, 0, 0, 0, 0) : ex(0, 0, 0, 0, 0, 0));
        chk($sformatf("t2_mw0 id=%0d cyc%0d", mid, k), o0, ex(1, s == 0, 0, 0, 0, 0));
      end
      drive(1, mid, 0, 0, 0);
      chk($sformatf("t2_idle_mw3 id=%0d", mid), o3, '0);
    end

    // T3: output handshake, confirmation arriving on the fifth request cycle
    drive(0, 0, 0, 0, 0);
    drive(1, 69, 1, 0, 0);
    chk("t3_issue", o3, '0);
    for (int k = 1; k <= 10; k++) begin
      bit c;
      c = (k >= 5 && k <= 8);
      drive(1, (k == 10) ? 4 : 69, 1, c, 0);
      if (k < 5)       chk($sformatf("t3_req%0d", k), o3, ex(0, 0, 0, 1, 0, 0));
      else if (k == 5) chk("t3_ack", o3, ex(1, 0, 0, 1, 0, 0));
      else if (k < 10) chk($sformatf("t3_rel%0d", k), o3, '0);
      else             chk("t3_next_mw0", o0, ex(1, 0, 0, 0, 0, 0));
    end
    // Input request with confirmation already high completes on its first cycle
    drive(1, 71, 1, 1, 0);
    chk("t3_in_issue", o3, '0);
    drive(1, 71, 1, 1, 0);
    chk("t3_in_immediate", o3, ex(1, 0, 1, 0, 0, 0));
    drive(1, 71, 1, 1, 0);
    chk("t3_in_rel", o3, '0);
    drive(1, 0, 0, 0, 0);
    chk("t3_in_drop", o3, '0);
    drive(1, 4, 1, 0, 0);
    chk("t3_in_next", o3, ex(1, 0, 0, 0, 0, 0));

    // T4: PAUSE entered with resume already high
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 70, 1, 0, 1);
    chk("t4_issue", o0, '0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 70, 1, 0, 1);
      chk($sformatf("t4_held%0d", k), o0, ex(0, 0, 1, 1, 0, 0));
    end
    drive(1, 70, 1, 0, 0);
    chk("t4_low", o0, ex(0, 0, 1, 1, 0, 0));
    drive(1, 70, 1, 0, 1);
    chk("t4_rise", o0, ex(1, 0, 1, 1, 0, 0));
    drive(1, 70, 0, 0, 1);
    chk("t4_after", o0, '0);
    chk("t4_after_mw3", o3, '0);

    // T5: sticky HALT
    drive(0, 0, 0, 0, 0);
    drive(1, 75, 1, 0, 0);
    chk("t5_issue", o3, '0);
    for (int k = 0; k < 100; k++) begin
      drive(1, $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      chk($sformatf("t5_halt_mw3[%0d]", k), o3, ex(0, 0, 0, 0, 1, 0));
      chk($sformatf("t5_halt_mw0[%0d]", k), o0, ex(0, 0, 0, 0, 1, 0));
    end
    drive(0, 4, 1, 0, 0);
    chk("t5_reset", o3, '0);
    drive(1, 4, 1, 0, 0);
    chk("t5_release", o3, ex(1, 0, 0, 0, 0, 0));

    // T6: input request with no confirmation
    drive(0, 0, 0, 0, 0);
    drive(1, 71, 1, 0, 0);
    chk("t6_issue", o3, '0);
`ifdef CTRL_IO_TIMEOUT_EN
    for (int k = 1; k <= TMO_CYC; k++) begin
      drive(1, 71, 1, 0, 0);
      chk($sformatf("t6_wait%0d", k), o3, ex(0, 0, 1, 0, 0, 0));
    end
    for (int k = 0; k < 20; k++) begin
      drive(1, 71, 1, $urandom_range(0, 1), $urandom_range(0, 1));
      chk($sformatf("t6_fault_mw3[%0d]", k), o3, ex(0, 0, 0, 0, 0, 1));
      chk($sformatf("t6_fault_mw0[%0d]", k), o0, ex(0, 0, 0, 0, 0, 1));
    end
`else
    for (int k = 1; k <= 1000; k++) begin
      drive(1, 71, 1, 0, 0);
      chk($sformatf("t6_wait%0d", k), o3, ex(0, 0, 1, 0, 0, 0));
    end
`endif

    // Randomized traffic against the reference model
    drive(0, 0, 0, 0, 0);
    m3 = mdl_reset();
    m0 = mdl_reset();
    rc = 1'b0;
    rrs = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      bit r, v;
      int i;
      r = ($urandom_range(0, 99) != 0);
      i = $urandom_range(0, 127);
      if (i == 75 && $urandom_range(0, 7) != 0) i = 4;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rc = ~rc;
      if ($urandom_range(0, 3) == 0) rrs = ~rrs;
      drive(r, i, v, rc, rrs);
      mdl_step(m3, 3, r, i, v, rc, rrs, e3);
      mdl_step(m0, 0, r, i, v, rc, rrs, e0);
      chk($sformatf("rand_mw3[%0d] id=%0d", k, i), o3, e3);
      chk($sformatf("rand_mw0[%0d] id=%0d", k, i), o0, e0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
